// File: rtl/read_dispatcher.sv
// read_dispatcher: routes the SRAM read packet stream to one of num_of_ports egress ports.
// Optional macro RD_DISPATCH_ERR_CNT_EN adds a saturating err_cnt output.
module read_dispatcher #(
  parameter int num_of_ports          = 16,
  parameter int dispatcher_data_width = 64,
  parameter int port_index_width      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_vld,
  input  logic                        rd_sop,
  input  logic                        rd_eop,
  input  logic [port_index_width-1:0] rd_dest,
  input  logic [dispatcher_data_width-1:0] rd_data,
  output logic                        rd_ready,
  input  logic [num_of_ports-1:0]     port_ready,
  output logic [num_of_ports-1:0]     out_vld,
  output logic [num_of_ports-1:0]     out_sop,
  output logic [num_of_ports-1:0]     out_eop,
  output logic [num_of_ports*dispatcher_data_width-1:0] data_out_p,
  output logic                        busy,
  output logic                        transfering
`ifdef RD_DISPATCH_ERR_CNT_EN
  ,
  output logic [7:0]                  err_cnt
`endif
);

  localparam int W = dispatcher_data_width;
  localparam logic [port_index_width:0] LP_NP =
    (port_index_width+1)'(num_of_ports);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [port_index_width-1:0] r_cur_dest;
  logic                        r_obuf_vld;
  logic [port_index_width-1:0] r_obuf_port;
  logic                        r_obuf_sop;
  logic                        r_obuf_eop;
  logic [W-1:0]                r_obuf_data;

  logic                        w_dest_ok;
  logic                        w_acc;
  logic                        w_drain;
  logic [num_of_ports-1:0]     w_onehot;
  logic                        w_sop_ok;
  logic                        w_sop_bad;
  logic                        w_body;
  logic                        w_stray;
  logic                        w_load;
  logic [port_index_width-1:0] w_load_port;

  assign w_dest_ok = ({1'b0, rd_dest} < LP_NP);

  always_comb begin
    w_onehot = '0;
    for (int p = 0; p < num_of_ports; p++)
      if (r_obuf_port == port_index_width'(p))
        w_onehot[p] = 1'b1;
  end

  assign w_drain  = r_obuf_vld & (|(w_onehot & port_ready));
  // Gated by rst so nothing is offered upstream while held in reset.
  assign rd_ready = rst & (~r_obuf_vld | w_drain);
  assign w_acc    = rd_vld & rd_ready;

  assign w_sop_ok  = rd_sop & w_dest_ok;
  assign w_sop_bad = rd_sop & ~w_dest_ok;
  assign w_body    = ~rd_sop & (r_state == S_XFER);
  assign w_stray   = ~rd_sop & (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cur_dest <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc && w_sop_ok)
        r_cur_dest <= rd_dest;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      if (rd_sop)
        w_state_nxt = (w_dest_ok && !rd_eop) ? S_XFER : S_IDLE;
      else if (r_state == S_XFER && rd_eop)
        w_state_nxt = S_IDLE;
    end
  end

  always_comb begin
    w_load      = 1'b0;
    w_load_port = r_cur_dest;
    if (w_acc) begin
      unique case (1'b1)
        w_sop_ok: begin
          w_load      = 1'b1;
          w_load_port = rd_dest;
        end
        w_body:    w_load = 1'b1;
        w_sop_bad: w_load = 1'b0;
        w_stray:   w_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_obuf_vld  <= 1'b0;
      r_obuf_port <= '0;
      r_obuf_sop  <= 1'b0;
      r_obuf_eop  <= 1'b0;
      r_obuf_data <= '0;
    end else if (w_load) begin
      r_obuf_vld  <= 1'b1;
      r_obuf_port <= w_load_port;
      r_obuf_sop  <= rd_sop;
      r_obuf_eop  <= rd_eop;
      r_obuf_data <= rd_data;
    end else if (w_drain) begin
      r_obuf_vld  <= 1'b0;
    end
  end

  assign out_vld = {num_of_ports{r_obuf_vld}} & w_onehot;
  assign out_sop = out_vld & {num_of_ports{r_obuf_sop}};
  assign out_eop = out_vld & {num_of_ports{r_obuf_eop}};

  always_comb begin
    data_out_p = '0;
    for (int p = 0; p < num_of_ports; p++)
      if (out_vld[p])
        data_out_p[p*W +: W] = r_obuf_data;
  end

  assign busy        = (r_state == S_XFER) | r_obuf_vld;
  assign transfering = w_acc;

`ifdef RD_DISPATCH_ERR_CNT_EN
  logic       w_err;
  logic [7:0] r_err_cnt;

  // Truncation (sop while a packet is open) counts as well as dropped beats.
  assign w_err = w_acc &
    (w_sop_bad | w_stray | (w_sop_ok & (r_state == S_XFER)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_err_cnt <= '0;
    else if (w_err && r_err_cnt != 8'hFF)
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_read_dispatcher.sv
// tb_read_dispatcher: directed scenarios plus a randomized run
// against a queue-based packet model (num_of_ports=12).
module tb_read_dispatcher;

  localparam int NP = 12;
  localparam int W  = 64;
  localparam int PW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            rd_vld = 1'b0;
  logic            rd_sop = 1'b0;
  logic            rd_eop = 1'b0;
  logic [PW-1:0]   rd_dest = '0;
  logic [W-1:0]    rd_data = '0;
  logic            rd_ready;
  logic [NP-1:0]   port_ready = '0;
  logic [NP-1:0]   out_vld;
  logic [NP-1:0]   out_sop;
  logic [NP-1:0]   out_eop;
  logic [NP*W-1:0] data_out_p;
  logic            busy;
  logic            transfering;
`ifdef RD_DISPATCH_ERR_CNT_EN
  logic [7:0]      err_cnt;
`endif

  read_dispatcher #(
    .num_of_ports(NP),
    .dispatcher_data_width(W),
    .port_index_width(PW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .rd_vld(rd_vld),
    .rd_sop(rd_sop),
    .rd_eop(rd_eop),
    .rd_dest(rd_dest),
    .rd_data(rd_data),
    .rd_ready(rd_ready),
    .port_ready(port_ready),
    .out_vld(out_vld),
    .out_sop(out_sop),
    .out_eop(out_eop),
    .data_out_p(data_out_p),
    .busy(busy),
    .transfering(transfering)
`ifdef RD_DISPATCH_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int exp_err = 0;

  typedef struct {
    int         port;
    logic       sop;
    logic       eop;
    logic [W-1:0] data;
  } beat_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic e,
                       input int dest, input logic [W-1:0] x);
    rd_vld  = v;
    rd_sop  = s;
    rd_eop  = e;
    rd_dest = PW'(dest);
    rd_data = x;
  endtask

  task automatic bump_err();
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
  endtask

  function automatic logic [NP-1:0] oh(input int p);
    logic [NP-1:0] r = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  function automatic logic [NP*W-1:0] expdp(input int p,
                                             input logic [W-1:0] d);
    logic [NP*W-1:0] r = '0;
    r[p*W +: W] = d;
    return r;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    port_ready = '1;
    drive(1, 1, 0, 5, rnd64());
    #1;
    n_chk++; if (rd_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", rd_ready); else n_pass++;
    n_chk++; if (transfering !== 1'b0) $display("FAIL rst_xfer got %b want 0", transfering); else n_pass++;
    n_chk++; if (out_vld !== '0) $display("FAIL rst_vld got %h want 0", out_vld); else n_pass++;
    n_chk++; if ((out_sop | out_eop) !== '0) $display("FAIL rst_flags got %h/%h want 0", out_sop, out_eop); else n_pass++;
    n_chk++; if (data_out_p !== '0) $display("FAIL rst_data got %h want 0", data_out_p); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
`ifdef RD_DISPATCH_ERR_CNT_EN
    n_chk++; if (err_cnt !== 8'd0) $display("FAIL rst_err got %0d want 0", err_cnt); else n_pass++;
`endif
    drive(0, 0, 0, 0, '0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_rel_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single();
    logic [W-1:0] d[3];
    port_ready = '1;
    for (int i = 0; i < 3; i++) d[i] = rnd64();
    for (int i = 0; i < 3; i++) begin
      drive(1, i == 0, i == 2, 5, d[i]);
      #1;
      n_chk++; if (rd_ready !== 1'b1) $display("FAIL single_ready beat%0d got %b want 1", i, rd_ready); else n_pass++;
      tick();
      n_chk++; if (out_vld !== oh(5)) $display("FAIL single_vld beat%0d got %h want %h", i, out_vld, oh(5)); else n_pass++;
      n_chk++; if (out_sop !== ((i == 0) ? oh(5) : '0)) $display("FAIL single_sop beat%0d got %h", i, out_sop); else n_pass++;
      n_chk++; if (out_eop !== ((i == 2) ? oh(5) : '0)) $display("FAIL single_eop beat%0d got %h", i, out_eop); else n_pass++;
      n_chk++; if (data_out_p[383:320] !== d[i]) $display("FAIL single_slice beat%0d got %h want %h", i, data_out_p[383:320], d[i]); else n_pass++;
      n_chk++; if (data_out_p !== expdp(5, d[i])) $display("FAIL single_data beat%0d other slices nonzero", i); else n_pass++;
      n_chk++; if (busy !== 1'b1) $display("FAIL single_busy beat%0d got %b want 1", i, busy); else n_pass++;
    end
    drive(0, 0, 0, 0, '0);
    tick();
    n_chk++; if (out_vld !== '0) $display("FAIL single_end_vld got %h want 0", out_vld); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL single_end_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_stall();
    logic [W-1:0] d[3];
    port_ready = '1;
    for (int i = 0; i < 3; i++) d[i] = rnd64();
    drive(1, 1, 0, 5, d[0]);
    tick();
    port_ready[5] = 1'b0;
    drive(1, 0, 0, 5, d[1]);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++; if (rd_ready !== 1'b0) $display("FAIL stall_ready cyc%0d got %b want 0", k, rd_ready); else n_pass++;
      n_chk++; if (transfering !== 1'b0) $display("FAIL stall_xfer cyc%0d got %b want 0", k, transfering); else n_pass++;
      n_chk++; if (out_vld !== oh(5) || out_sop !== oh(5)) $display("FAIL stall_hold cyc%0d vld %h sop %h want %h", k, out_vld, out_sop, oh(5)); else n_pass++;
      n_chk++; if (data_out_p !== expdp(5, d[0])) $display("FAIL stall_data cyc%0d got %h want %h", k, data_out_p[383:320], d[0]); else n_pass++;
      tick();
    end
    port_ready = '1;
    #1;
    n_chk++; if (rd_ready !== 1'b1) $display("FAIL stall_release got %b want 1", rd_ready); else n_pass++;
    tick();
    n_chk++; if (data_out_p !== expdp(5, d[1]) || out_sop !== '0) $display("FAIL stall_beat2 got %h sop %h want %h", data_out_p[383:320], out_sop, d[1]); else n_pass++;
    drive(1, 0, 1, 5, d[2]);
    tick();
    n_chk++; if (data_out_p !== expdp(5, d[2]) || out_eop !== oh(5)) $display("FAIL stall_beat3 got %h eop %h want %h", data_out_p[383:320], out_eop, d[2]); else n_pass++;
    drive(0, 0, 0, 0, '0);
    tick();
    n_chk++; if (out_vld !== '0 || busy !== 1'b0) $display("FAIL stall_end vld %h busy %b want 0", out_vld, busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ports[3] = '{0, NP-1, 7};
    logic [W-1:0] d;
    port_ready = '1;
    for (int i = 0; i < 3; i++) begin
      d = rnd64();
      drive(1, 1, 1, ports[i], d);
      tick();
      n_chk++; if (out_vld !== oh(ports[i])) $display("FAIL b2b_vld port%0d got %h want %h", ports[i], out_vld, oh(ports[i])); else n_pass++;
      n_chk++; if (out_sop !== oh(ports[i]) || out_eop !== oh(ports[i])) $display("FAIL b2b_flags port%0d sop %h eop %h", ports[i], out_sop, out_eop); else n_pass++;
      n_chk++; if (data_out_p !== expdp(ports[i], d)) $display("FAIL b2b_data port%0d got %h want %h", ports[i], data_out_p, d); else n_pass++;
    end
    drive(0, 0, 0, 0, '0);
    tick();
    n_chk++; if (out_vld !== '0 || busy !== 1'b0) $display("FAIL b2b_end vld %h busy %b want 0", out_vld, busy); else n_pass++;
  endtask

  task automatic test_malformed();
    port_ready = '1;
    drive(1, 0, 0, 3, rnd64());
    #1;
    n_chk++; if (transfering !== 1'b1) $display("FAIL mal_stray_acc got %b want 1", transfering); else n_pass++;
    bump_err();
    tick();
    n_chk++; if (out_vld !== '0 || busy !== 1'b0) $display("FAIL mal_stray vld %h busy %b want 0", out_vld, busy); else n_pass++;
    drive(1, 1, 0, 13, rnd64());
    #1;
    n_chk++; if (transfering !== 1'b1) $display("FAIL mal_dest_acc got %b want 1", transfering); else n_pass++;
    bump_err();
    tick();
    n_chk++; if (out_vld !== '0 || busy !== 1'b0) $display("FAIL mal_dest vld %h busy %b want 0", out_vld, busy); else n_pass++;
`ifdef RD_DISPATCH_ERR_CNT_EN
    n_chk++; if (err_cnt !== 8'(exp_err)) $display("FAIL mal_err got %0d want %0d", err_cnt, exp_err); else n_pass++;
`endif
    drive(1, 0, 1, 2, rnd64());
    bump_err();
    tick();
    n_chk++; if (out_vld !== '0) $display("FAIL mal_after_bad got %h want 0", out_vld); else n_pass++;
    drive(0, 0, 0, 0, '0);
    tick();
  endtask

  task automatic test_truncate();
    logic [W-1:0] d[3];
    int bad = 0;
    port_ready = '1;
    for (int i = 0; i < 3; i++) d[i] = rnd64();
    drive(1, 1, 0, 2, d[0]);
    tick();
    n_chk++; if (out_vld !== oh(2) || out_sop !== oh(2) || out_eop !== '0) $display("FAIL trunc_b0 vld %h sop %h eop %h", out_vld, out_sop, out_eop); else n_pass++;
    drive(1, 0, 0, 2, d[1]);
    tick();
    n_chk++; if (data_out_p !== expdp(2, d[1]) || out_sop !== '0 || out_eop !== '0) $display("FAIL trunc_b1 got %h sop %h eop %h", data_out_p[191:128], out_sop, out_eop); else n_pass++;
    drive(1, 1, 1, 9, d[2]);
    bump_err();
    tick();
    n_chk++; if (out_vld !== oh(9) || out_sop !== oh(9) || out_eop !== oh(9)) $display("FAIL trunc_new vld %h sop %h eop %h want %h", out_vld, out_sop, out_eop, oh(9)); else n_pass++;
    n_chk++; if (data_out_p !== expdp(9, d[2])) $display("FAIL trunc_new_data got %h want %h", data_out_p, d[2]); else n_pass++;
    drive(0, 0, 0, 0, '0);
    tick();
    n_chk++; if (busy !== 1'b0) $display("FAIL trunc_end_busy got %b want 0", busy); else n_pass++;
`ifdef RD_DISPATCH_ERR_CNT_EN
    n_chk++; if (err_cnt !== 8'(exp_err)) $display("FAIL trunc_err got %0d want %0d", err_cnt, exp_err); else n_pass++;
`endif
    for (int i = 0; i < 300; i++) begin
      drive(1, 0, 0, 1, rnd64());
      bump_err();
      tick();
      if (out_vld !== '0) bad++;
    end
    drive(0, 0, 0, 0, '0);
    tick();
    n_chk++; if (bad != 0) $display("FAIL sat_dropped got %0d beats out want 0", bad); else n_pass++;
`ifdef RD_DISPATCH_ERR_CNT_EN
    n_chk++; if (err_cnt !== 8'd255) $display("FAIL sat_err got %0d want 255", err_cnt); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d[2];
    for (int i = 0; i < 2; i++) d[i] = rnd64();
    port_ready = '1;
    port_ready[3] = 1'b0;
    drive(1, 1, 0, 3, rnd64());
    tick();
    drive(1, 0, 0, 3, rnd64());
    #2;
    rst = 1'b0;
    #1;
    n_chk++; if (out_vld !== '0 || out_sop !== '0 || out_eop !== '0) $display("FAIL rmid_flags vld %h sop %h eop %h", out_vld, out_sop, out_eop); else n_pass++;
    n_chk++; if (data_out_p !== '0 || busy !== 1'b0) $display("FAIL rmid_state busy %b data nonzero", busy); else n_pass++;
    n_chk++; if (rd_ready !== 1'b0 || transfering !== 1'b0) $display("FAIL rmid_ready got %b/%b want 0", rd_ready, transfering); else n_pass++;
`ifdef RD_DISPATCH_ERR_CNT_EN
    n_chk++; if (err_cnt !== 8'd0) $display("FAIL rmid_err got %0d want 0", err_cnt); else n_pass++;
`endif
    exp_err = 0;
    @(negedge clk);
    rst = 1'b1;
    port_ready = '1;
    drive(0, 0, 0, 0, '0);
    tick();
    n_chk++; if (out_vld !== '0 || busy !== 1'b0) $display("FAIL rmid_rel vld %h busy %b want 0", out_vld, busy); else n_pass++;
    drive(1, 1, 0, 4, d[0]);
    tick();
    n_chk++; if (out_vld !== oh(4) || out_sop !== oh(4) || data_out_p !== expdp(4, d[0])) $display("FAIL rmid_b0 vld %h sop %h", out_vld, out_sop); else n_pass++;
    drive(1, 0, 1, 4, d[1]);
    tick();
    n_chk++; if (out_eop !== oh(4) || data_out_p !== expdp(4, d[1])) $display("FAIL rmid_b1 eop %h got %h", out_eop, data_out_p[319:256]); else n_pass++;
    drive(0, 0, 0, 0, '0);
    tick();
    n_chk++; if (busy !== 1'b0) $display("FAIL rmid_end_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_random();
    beat_t q[$];
    bit in_pkt = 0;
    int cur = 0;
    logic v, s, e, exp_rdy;
    int dest;
    logic [W-1:0] x;
    logic [NP-1:0] ev;
    logic [NP*W-1:0] edp;
    int flush;
    for (int c = 0; c < 3000; c++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0);
      e = ($urandom_range(0, 2) == 0);
      dest = $urandom_range(0, 15);
      x = rnd64();
      for (int p = 0; p < NP; p++) port_ready[p] = ($urandom_range(0, 3) != 0);
      drive(v, s, e, dest, x);
      #1;
      exp_rdy = (q.size() == 0) || port_ready[q[0].port];
      ev = '0;
      edp = '0;
      if (q.size() != 0) begin
        ev = oh(q[0].port);
        edp = expdp(q[0].port, q[0].data);
      end
      n_chk++; if (rd_ready !== exp_rdy) $display("FAIL rnd_ready cyc%0d got %b want %b", c, rd_ready, exp_rdy); else n_pass++;
      n_chk++; if (out_vld !== ev) $display("FAIL rnd_vld cyc%0d got %h want %h", c, out_vld, ev); else n_pass++;
      n_chk++; if (out_sop !== ((q.size() != 0 && q[0].sop) ? ev : '0)) $display("FAIL rnd_sop cyc%0d got %h", c, out_sop); else n_pass++;
      n_chk++; if (out_eop !== ((q.size() != 0 && q[0].eop) ? ev : '0)) $display("FAIL rnd_eop cyc%0d got %h", c, out_eop); else n_pass++;
      n_chk++; if (data_out_p !== edp) $display("FAIL rnd_data cyc%0d mismatch on port data", c); else n_pass++;
      if (q.size() != 0 && port_ready[q[0].port]) void'(q.pop_front());
      if (v && exp_rdy) begin
        if (s) begin
          if (dest < NP) begin
            if (in_pkt) bump_err();
            q.push_back('{dest, 1'b1, e, x});
            in_pkt = !e;
            cur = dest;
          end else begin
            bump_err();
            in_pkt = 0;
          end
        end else if (in_pkt) begin
          q.push_back('{cur, 1'b0, e, x});
          in_pkt = !e;
        end else begin
          bump_err();
        end
      end
      tick();
    end
    drive(0, 0, 0, 0, '0);
    port_ready = '1;
    flush = 0;
    while (q.size() != 0 && flush < 8) begin
      void'(q.pop_front());
      tick();
      flush++;
    end
    n_chk++; if (out_vld !== '0) $display("FAIL rnd_flush_vld got %h want 0", out_vld); else n_pass++;
    n_chk++; if (busy !== in_pkt) $display("FAIL rnd_busy got %b want %b", busy, in_pkt); else n_pass++;
`ifdef RD_DISPATCH_ERR_CNT_EN
    n_chk++; if (err_cnt !== 8'(exp_err)) $display("FAIL rnd_err got %0d want %0d", err_cnt, exp_err); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_malformed();
    test_truncate();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
